centering_block: RTL

- Mean-removal stage directly upstream of the covariance block.
- Captures a frame of N four-channel samples, computes the per-channel mean, then streams out N mean-removed samples Xcen1..Xcen4 on consecutive cycles.
- Xcen1..Xcen4 are the signed 16-bit centred inputs the covariance stage consumes; Cen_busy and DONE let the controller sequence the next stage.

---
 rtl/centering_block.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/centering_block.sv
// Mean-removal stage: buffers a frame of N four-channel samples, then replays them minus the per-channel mean.
// Latency: means registered in the single MEAN cycle m; centred samples valid m+2..m+N+1, DONE at m+N+1.
// No backpressure: output streams on consecutive cycles. GO is ignored while Cen_busy; X_valid only used in LOAD.
//
// Ports: CLK/RSTn (async active-low), GO start request, X_valid + X1..X4 raw samples,
//        Xcen1..Xcen4 + Xcen_valid centred output, Mean1..Mean4 frame means,
//        Cen_busy frame in progress, DONE one-cycle end-of-frame pulse.
module centering_block #(
    parameter int DW     = 16,
    parameter int N_LOG2 = 6
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 GO,
    input  logic                 X_valid,
    input  logic signed [DW-1:0] X1,
    input  logic signed [DW-1:0] X2,
    input  logic signed [DW-1:0] X3,
    input  logic signed [DW-1:0] X4,
    output logic signed [DW-1:0] Xcen1,
    output logic signed [DW-1:0] Xcen2,
    output logic signed [DW-1:0] Xcen3,
    output logic signed [DW-1:0] Xcen4,
    output logic                 Xcen_valid,
    output logic signed [DW-1:0] Mean1,
    output logic signed [DW-1:0] Mean2,
    output logic signed [DW-1:0] Mean3,
    output logic signed [DW-1:0] Mean4,
    output logic                 Cen_busy,
    output logic                 DONE
);
    localparam int N  = 1 << N_LOG2;
    localparam int AW = DW + N_LOG2;   // accumulator wide enough for N full-scale samples

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MEAN, S_OUT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [N_LOG2-1:0]     r_cnt;
    logic [N_LOG2:0]       r_rd_addr;  // MSB set means all N entries replayed (drain cycle)
    logic signed [AW-1:0]  r_acc  [4];
    logic signed [DW-1:0]  r_mean [4];
    logic signed [DW-1:0]  r_xcen [4];
    logic                  r_xcen_vld;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DW-1:0]       r_buf  [N];

    logic signed [DW-1:0]  w_x    [4];
    logic [4*DW-1:0]       w_rd_word;
    logic signed [DW-1:0]  w_rd_x [4];
    logic signed [DW:0]    w_diff [4];
    logic signed [DW-1:0]  w_sat  [4];

    assign w_x[0] = X1;
    assign w_x[1] = X2;
    assign w_x[2] = X3;
    assign w_x[3] = X4;

    assign w_rd_word = r_buf[r_rd_addr[N_LOG2-1:0]];

    // Centre in DW+1 bits, then clamp back to DW bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_rd_x[i] = w_rd_word[i*DW +: DW];
            w_diff[i] = {w_rd_x[i][DW-1], w_rd_x[i]} - {r_mean[i][DW-1], r_mean[i]};
            w_sat[i]  = w_diff[i][DW-1:0];
            if (w_diff[i][DW] != w_diff[i][DW-1]) begin
                w_sat[i] = w_diff[i][DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (GO) w_next = S_LOAD;
            S_LOAD: if (X_valid && (&r_cnt)) w_next = S_MEAN;
            S_MEAN: w_next = S_OUT;
            S_OUT:  if (r_rd_addr[N_LOG2]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sample buffer carries no reset; its contents are meaningless until loaded.
    always_ff @(posedge CLK) begin
        if (r_state == S_LOAD && X_valid) r_buf[r_cnt] <= {X4, X3, X2, X1};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt      <= '0;
            r_rd_addr  <= '0;
            r_xcen_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]  <= '0;
                r_mean[i] <= '0;
                r_xcen[i] <= '0;
            end
        end else begin
            r_xcen_vld <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (GO) begin
                        r_cnt     <= '0;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        for (int i = 0; i < 4; i++) r_acc[i] <= '0;
                    end
                end
                S_LOAD: begin
                    if (X_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        for (int i = 0; i < 4; i++)
                            r_acc[i] <= r_acc[i] + {{N_LOG2{w_x[i][DW-1]}}, w_x[i]};
                    end
                end
                S_MEAN: begin
                    // Arithmetic shift floors toward minus infinity; result always fits DW bits.
                    for (int i = 0; i < 4; i++) r_mean[i] <= DW'(r_acc[i] >>> N_LOG2);
                    r_rd_addr <= '0;
                end
                S_OUT: begin
                    if (!r_rd_addr[N_LOG2]) begin
                        for (int i = 0; i < 4; i++) r_xcen[i] <= w_sat[i];
                        r_xcen_vld <= 1'b1;
                        r_done     <= &r_rd_addr[N_LOG2-1:0];
                        r_rd_addr  <= r_rd_addr + 1'b1;
                    end else begin
                        // Drain cycle: last sample and DONE are on the outputs now.
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Xcen1      = r_xcen[0];
    assign Xcen2      = r_xcen[1];
    assign Xcen3      = r_xcen[2];
    assign Xcen4      = r_xcen[3];
    assign Mean1      = r_mean[0];
    assign Mean2      = r_mean[1];
    assign Mean3      = r_mean[2];
    assign Mean4      = r_mean[3];
    assign Xcen_valid = r_xcen_vld;
    assign Cen_busy   = r_busy;
    assign DONE       = r_done;

endmodule
